// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one uart_tx between two byte requesters, pacing
// writes to whole frames and letting a requester lock the transmitter for a packet.
module uart_tx_sched #(
    parameter int CLOCKS_PER_BAUD = 104,
    parameter int FRAME_BITS      = 10,
    parameter int HOLD_TIMEOUT    = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_last_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_last_i,
    output logic       req1_ready_o,
    output logic       write_o,
    output logic [7:0] data_o,
    output logic [1:0] owner_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int FRAME_CLOCKS = CLOCKS_PER_BAUD * FRAME_BITS;
    localparam int CNT_W        = (FRAME_CLOCKS > 1) ? $clog2(FRAME_CLOCKS) : 1;
    localparam int IDLE_W       = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN   = (HOLD_TIMEOUT != 0);

    localparam logic [CNT_W-1:0]  CNT_RESET  = CNT_W'(FRAME_CLOCKS - 1);
    // The SEND cycle is the first clock of the frame, so WAIT covers the remaining ones.
    localparam logic [CNT_W-1:0]  CNT_SEND   = CNT_W'(FRAME_CLOCKS - 2);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_ZERO  = IDLE_W'(0);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_HOLD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [IDLE_W-1:0] idle_r, idle_s;
    logic              rr_last_r, rr_last_s;
    logic [1:0]        owner_r, owner_s;
    logic [7:0]        data_r, data_s;
    logic              last_r, last_s;
    logic              write_r, write_s;
    logic              busy_r, busy_s;
    logic              timeout_r, timeout_s;
    logic              sel_s;
    logic              grant0_s, grant1_s;

    // Grant selection and next-state / next-output computation.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idle_s    = idle_r;
        rr_last_s = rr_last_r;
        owner_s   = owner_r;
        data_s    = data_r;
        last_s    = last_r;
        write_s   = 1'b0;
        busy_s    = 1'b0;
        timeout_s = 1'b0;
        grant0_s  = 1'b0;
        grant1_s  = 1'b0;

        if (req0_valid_i && req1_valid_i) begin
            sel_s = ~rr_last_r;
        end else if (req1_valid_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end

        case (state_r)
            ST_ARB: begin
                grant0_s = ~sel_s & req0_valid_i;
                grant1_s = sel_s & req1_valid_i;
            end
            ST_HOLD: begin
                grant0_s = owner_r[0] & req0_valid_i;
                grant1_s = owner_r[1] & req1_valid_i;
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase

        case (state_r)
            ST_ARB, ST_HOLD: begin
                if (grant0_s || grant1_s) begin
                    data_s  = grant1_s ? req1_data_i : req0_data_i;
                    last_s  = grant1_s ? req1_last_i : req0_last_i;
                    owner_s = grant1_s ? 2'b10 : 2'b01;
                    if (state_r == ST_ARB) begin
                        rr_last_s = grant1_s;
                    end else begin
                        rr_last_s = rr_last_r;
                    end
                    write_s = 1'b1;
                    idle_s  = IDLE_ZERO;
                    state_s = ST_SEND;
                end else if ((state_r == ST_HOLD) && TIMEOUT_EN) begin
                    // A locked owner that stalls too long forfeits the transmitter.
                    if (idle_r == IDLE_LIMIT) begin
                        timeout_s = 1'b1;
                        owner_s   = 2'b00;
                        idle_s    = IDLE_ZERO;
                        state_s   = ST_ARB;
                    end else begin
                        idle_s = idle_r + IDLE_ONE;
                    end
                end else begin
                    idle_s = IDLE_ZERO;
                end
            end
            ST_SEND: begin
                cnt_s   = CNT_SEND;
                busy_s  = 1'b1;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    idle_s = IDLE_ZERO;
                    if (last_r) begin
                        owner_s = 2'b00;
                        state_s = ST_ARB;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end else begin
                    cnt_s  = cnt_r - CNT_ONE;
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_ARB;
            end
        endcase
    end

    // State and registered-output update; reset parks in WAIT so an in-flight frame can finish.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_WAIT;
            cnt_r     <= CNT_RESET;
            idle_r    <= IDLE_ZERO;
            rr_last_r <= 1'b1;
            owner_r   <= 2'b00;
            data_r    <= 8'h00;
            last_r    <= 1'b1;
            write_r   <= 1'b0;
            busy_r    <= 1'b1;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            idle_r    <= idle_s;
            rr_last_r <= rr_last_s;
            owner_r   <= owner_s;
            data_r    <= data_s;
            last_r    <= last_s;
            write_r   <= write_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
        end
    end

    assign req0_ready_o = grant0_s;
    assign req1_ready_o = grant1_s;
    assign write_o      = write_r;
    assign data_o       = data_r;
    assign owner_o      = owner_r;
    assign busy_o       = busy_r;
    assign timeout_o    = timeout_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table, hand-written corner sequences,
// and a randomized run against a time-based reference model.
module tb_uart_tx_sched;

    localparam int CPB = 4;
    localparam int FB  = 10;
    localparam int FC  = CPB * FB;
    localparam int HT  = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
    logic [7:0] req1_data = 8'h00;
    logic       write_o, busy_o, timeout_o;
    logic [7:0] data_o;
    logic [1:0] owner_o;

    uart_tx_sched #(.CLOCKS_PER_BAUD(CPB), .FRAME_BITS(FB), .HOLD_TIMEOUT(HT)) dut (
        .clock(clock), .reset(reset),
        .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_last_i(req0_last), .req0_ready_o(req0_ready),
        .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_last_i(req1_last), .req1_ready_o(req1_ready),
        .write_o(write_o), .data_o(data_o), .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    endtask

    // Leaves the bench at the drive point of post-reset cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        int         exp_wait;
        logic [1:0] exp_owner;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int w;
        int wc[$];
        logic [7:0] wd[$];
        int r1_first, t_first, t_cnt, w0, idx;
        logic [1:0] own_h[0:399];
        logic [7:0] pkt[3];
        logic acc0, acc1;

        // Single-byte transactions from idle; round-robin pointer starts favouring req0.
        tbl[0] = '{1'b1, 8'h41, 1'b0, 8'h00, FC, 2'b01, 8'h41};
        tbl[1] = '{1'b1, 8'hA0, 1'b1, 8'hB0, 0,  2'b10, 8'hB0};
        tbl[2] = '{1'b1, 8'hC0, 1'b1, 8'hD0, 0,  2'b01, 8'hC0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 8'hE1, 0,  2'b10, 8'hE1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 8'hF2, 0,  2'b10, 8'hF2};
        tbl[5] = '{1'b1, 8'h11, 1'b1, 8'h22, 0,  2'b01, 8'h11};
        tbl[6] = '{1'b1, 8'h5A, 1'b0, 8'h00, 0,  2'b01, 8'h5A};
        tbl[7] = '{1'b1, 8'h33, 1'b1, 8'h44, 0,  2'b10, 8'h44};

        do_reset();
        settle();
        check("rst_write", write_o, 1'b0);
        check("rst_data", data_o, 8'h00);
        check("rst_owner", owner_o, 2'b00);
        check("rst_busy", busy_o, 1'b1);
        check("rst_timeout", timeout_o, 1'b0);
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);

        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = 1'b1;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_last = 1'b1;
            w = 0;
            settle();
            while (!(req0_ready || req1_ready) && w < FC + 10) begin
                cyc(); w++; settle();
            end
            check("tbl_wait", w, tbl[i].exp_wait);
            check("tbl_ready", {req1_ready, req0_ready}, tbl[i].exp_owner);
            cyc();
            req0_valid = 1'b0; req1_valid = 1'b0;
            settle();
            check("tbl_write", write_o, 1'b1);
            check("tbl_data", data_o, tbl[i].exp_data);
            check("tbl_owner", owner_o, tbl[i].exp_owner);
            check("tbl_busy_send", busy_o, 1'b0);
            cyc(); settle();
            check("tbl_write_once", write_o, 1'b0);
            check("tbl_data_hold", data_o, tbl[i].exp_data);
            repeat (FC - 2) cyc();
            settle();
            check("tbl_busy_end", busy_o, 1'b1);
            check("tbl_owner_end", owner_o, tbl[i].exp_owner);
            cyc(); settle();
            check("tbl_busy_done", busy_o, 1'b0);
            check("tbl_owner_done", owner_o, 2'b00);
        end

        // Both requesters always valid: alternate service, writes FC+1 apart.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hA0; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'hB0; req1_last = 1'b1;
        wc.delete(); wd.delete();
        for (int c = 0; c < 5 * FC + 10 && wc.size() < 4; c++) begin
            settle();
            if (write_o) begin wc.push_back(c); wd.push_back(data_o); end
            cyc();
        end
        check("rr_count", wc.size(), 4);
        if (wc.size() > 0) check("rr_first_write", wc[0], FC + 1);
        for (int i = 0; i < wc.size(); i++) begin
            check("rr_order", wd[i], (i % 2 == 0) ? 8'hA0 : 8'hB0);
            if (i > 0) check("rr_spacing", wc[i] - wc[i-1], FC + 1);
        end

        // Packet lock: req1 waits until req0's 3-byte packet has fully gone out.
        do_reset();
        pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
        idx = 0;
        req0_valid = 1'b1; req0_data = pkt[0]; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h77; req1_last = 1'b1;
        wc.delete(); wd.delete();
        r1_first = -1;
        for (int c = 0; c < 6 * FC && wc.size() < 4; c++) begin
            settle();
            if (write_o) begin wc.push_back(c); wd.push_back(data_o); end
            if (req1_ready && r1_first < 0) r1_first = c;
            acc0 = req0_ready && req0_valid;
            acc1 = req1_ready && req1_valid;
            cyc();
            if (acc0) begin
                idx++;
                if (idx < 3) begin
                    req0_data = pkt[idx];
                    req0_last = (idx == 2);
                end else begin
                    req0_valid = 1'b0;
                end
            end
            if (acc1) req1_valid = 1'b0;
        end
        check("lock_count", wc.size(), 4);
        if (wc.size() == 4) begin
            check("lock_b0", wd[0], 8'h01);
            check("lock_b1", wd[1], 8'h02);
            check("lock_b2", wd[2], 8'h03);
            check("lock_b3", wd[3], 8'h77);
            check("lock_gap01", wc[1] - wc[0], FC + 1);
            check("lock_gap12", wc[2] - wc[1], FC + 1);
            check("lock_gap23", wc[3] - wc[2], FC + 1);
            check("lock_r1_ready", r1_first, wc[2] + FC);
        end
        idle_inputs();

        // Locked owner stalls: lock dropped HT cycles after entering HOLD, req1 then served.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h66; req1_last = 1'b1;
        t_first = -1; t_cnt = 0; r1_first = -1; w0 = -1;
        for (int c = 0; c < 400; c++) begin
            settle();
            own_h[c] = owner_o;
            if (timeout_o) begin t_cnt++; if (t_first < 0) t_first = c; end
            if (write_o && w0 < 0) w0 = c;
            if (req1_ready && r1_first < 0) r1_first = c;
            acc0 = req0_ready && req0_valid;
            acc1 = req1_ready && req1_valid;
            cyc();
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
        end
        check("to_first_write", w0, FC + 1);
        check("to_pulse_cycle", t_first, 2 * FC + 1 + HT);
        check("to_pulse_count", t_cnt, 1);
        check("to_r1_ready", r1_first, 2 * FC + 1 + HT);
        check("to_owner_before", own_h[2 * FC + HT], 2'b01);
        check("to_owner_after", own_h[2 * FC + 1 + HT], 2'b00);

        // Reset in the middle of WAIT.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h99; req0_last = 1'b1;
        repeat (FC + 1) cyc();
        settle();
        check("mr_write", write_o, 1'b1);
        check("mr_data", data_o, 8'h99);
        repeat (20) cyc();
        settle();
        check("mr_busy_mid", busy_o, 1'b1);
        reset = 1'b1;
        cyc(); settle();
        check("mr_rst_write", write_o, 1'b0);
        check("mr_rst_data", data_o, 8'h00);
        check("mr_rst_owner", owner_o, 2'b00);
        check("mr_rst_busy", busy_o, 1'b1);
        check("mr_rst_timeout", timeout_o, 1'b0);
        check("mr_rst_ready", req0_ready, 1'b0);
        reset = 1'b0;
        w = 0;
        while (!req0_ready && w < FC + 10) begin
            cyc(); w++; settle();
        end
        check("mr_first_accept", w, FC);
        idle_inputs();

        // Randomized traffic against a frame-timing reference model.
        begin
            int avail_at, send_at, lock, idle, rr, sel;
            bit pend_last, to_e, acc;
            logic [1:0] own_e;
            logic [7:0] dat_e;
            logic v[2];
            logic [7:0] d[2];
            logic l[2];
            int quiet[2];
            bit acc_n[2];

            do_reset();
            avail_at = FC; send_at = -1; lock = -1; idle = 0; rr = 1;
            pend_last = 1'b0; to_e = 1'b0; own_e = 2'b00; dat_e = 8'h00;
            for (int n = 0; n < 2; n++) begin
                v[n] = 1'b0; d[n] = 8'h00; l[n] = 1'b0; quiet[n] = 0; acc_n[n] = 1'b0;
            end

            for (int c = 0; c < 4000; c++) begin
                for (int n = 0; n < 2; n++) begin
                    if (acc_n[n]) v[n] = 1'b0;
                    if (quiet[n] == 0 && $urandom_range(199, 0) == 0) quiet[n] = $urandom_range(160, 60);
                    if (quiet[n] > 0) begin
                        quiet[n]--;
                        v[n] = 1'b0;
                    end else if (!v[n]) begin
                        if ($urandom_range(3, 0) == 0) begin
                            v[n] = 1'b1;
                            d[n] = 8'($urandom);
                            l[n] = ($urandom_range(2, 0) != 0);
                        end
                    end else if ($urandom_range(15, 0) == 0) begin
                        v[n] = 1'b0;
                    end
                end
                req0_valid = v[0]; req0_data = d[0]; req0_last = l[0];
                req1_valid = v[1]; req1_data = d[1]; req1_last = l[1];
                settle();

                if (c == avail_at && pend_last) begin
                    lock = -1; own_e = 2'b00; pend_last = 1'b0;
                end
                sel = -1;
                if (c >= avail_at) begin
                    if (lock >= 0) sel = lock;
                    else if (v[0] && v[1]) sel = 1 - rr;
                    else if (v[1]) sel = 1;
                    else sel = 0;
                end
                acc = 1'b0;
                if (sel >= 0) acc = v[sel];
                acc_n[0] = acc && (sel == 0);
                acc_n[1] = acc && (sel == 1);

                check("rnd_ready0", req0_ready, acc_n[0]);
                check("rnd_ready1", req1_ready, acc_n[1]);
                check("rnd_write", write_o, (c == send_at));
                check("rnd_data", data_o, dat_e);
                check("rnd_owner", owner_o, own_e);
                check("rnd_busy", busy_o, (c < avail_at) && (c != send_at));
                check("rnd_timeout", timeout_o, to_e);

                to_e = 1'b0;
                if (acc) begin
                    dat_e = d[sel];
                    own_e = (sel == 1) ? 2'b10 : 2'b01;
                    if (lock < 0) rr = sel;
                    lock = sel;
                    pend_last = l[sel];
                    send_at = c + 1;
                    avail_at = c + 1 + FC;
                    idle = 0;
                end else if (c >= avail_at && lock >= 0) begin
                    idle++;
                    if (idle == HT) begin
                        to_e = 1'b1; own_e = 2'b00; lock = -1; idle = 0;
                    end
                end
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
